microcode_loader: RTL

//  Writer side of the 65C02 microcode control store. Accepts a byte stream (valid/ready) from a host/boot

---
 rtl/microcode_loader_if.sv | 33 +++
 rtl/microcode_loader.sv | 134 +++++++++++++
 2 files changed

// File: rtl/microcode_loader_if.sv
// Bus bundle between a boot/host byte source, the microcode loader and the
// control-store write port.
//   start            : pulse, begin loading a new image
//   in_data/in_valid : stream byte offered by the host
//   in_ready         : loader accepts a byte this cycle
//   we/waddr/wdata   : one-cycle control-store write strobe, address, data
//   busy/done/err    : load in progress / image good / image bad
// Modports: slave = the loader itself, master = the host/boot side.
interface microcode_loader_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, we, waddr, wdata, busy, done, err
  );

  modport master (
    output start, in_data, in_valid,
    input  in_ready, we, waddr, wdata, busy, done, err
  );
endinterface

// File: rtl/microcode_loader.sv
// Writer side of the 65C02 microcode control store.
// Packs a valid/ready byte stream little-endian into DATA_WIDTH-bit words and
// writes them to control-store addresses 0..WORDS-1, one write strobe per word.
// The stream ends with a checksum byte: the 8-bit wrap-around sum of every
// image byte plus the checksum byte must be zero for done, otherwise err.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : microcode_loader_if.slave (start, stream, write port, status)
module microcode_loader #(
  parameter int ADDR_WIDTH = 9,
  parameter int WORDS      = 512,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  microcode_loader_if.slave     bus
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIDX_W-1:0]     LAST_BYTE = BIDX_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(WORDS - 1);

  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("microcode_loader: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (WORDS < 1 || WORDS > (1 << ADDR_WIDTH)) begin : g_bad_words
    $error("microcode_loader: WORDS must be in 1..2**ADDR_WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state, state_nxt;
  logic [BIDX_W-1:0]     byte_idx;
  logic [ADDR_WIDTH-1:0] word_cnt;
  logic [7:0]            sum;
  logic [DATA_WIDTH-1:0] asm_word;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  in_ready;
  logic                  xfer;
  logic                  start_ok;
  logic                  word_full;
  logic [7:0]            sum_plus;
  logic [DATA_WIDTH-1:0] word_next;

  // Ready, busy and the sticky result flags are pure decodes of the state
  // register, so they change exactly one cycle after the deciding transfer.
  assign in_ready  = (state == S_LOAD) || (state == S_CHECK);
  assign xfer      = bus.in_valid && in_ready;
  assign start_ok  = bus.start && !in_ready;
  assign word_full = (byte_idx == LAST_BYTE);
  assign sum_plus  = sum + bus.in_data;

  assign bus.in_ready = in_ready;
  assign bus.busy     = in_ready;
  assign bus.done     = (state == S_DONE);
  assign bus.err      = (state == S_ERROR);
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;

  // Word under assembly with the current byte merged into its lane, so the
  // final byte of a word can be written out without an extra cycle.
  always_comb begin
    word_next = asm_word;
    for (int k = 0; k < BYTES; k++) begin
      if (byte_idx == BIDX_W'(k)) word_next[8*k +: 8] = bus.in_data;
    end
  end

  // NOTE: every signal assigned in always_comb gets its default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start_ok) state_nxt = S_LOAD;
      S_LOAD:  if (xfer && word_full && word_cnt == LAST_WORD) state_nxt = S_CHECK;
      S_CHECK: if (xfer) state_nxt = (sum_plus == 8'h00) ? S_DONE : S_ERROR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx <= '0;
      word_cnt <= '0;
      sum      <= '0;
      asm_word <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      we_q <= 1'b0;
      if (start_ok) begin
        byte_idx <= '0;
        word_cnt <= '0;
        sum      <= '0;
        asm_word <= '0;
      end
      if (state == S_LOAD && xfer) begin
        sum      <= sum_plus;
        asm_word <= word_next;
        if (word_full) begin
          byte_idx <= '0;
          we_q     <= 1'b1;
          waddr_q  <= word_cnt;
          wdata_q  <= word_next;
          word_cnt <= word_cnt + ADDR_WIDTH'(1);
        end else begin
          byte_idx <= byte_idx + BIDX_W'(1);
        end
      end
      if (state == S_CHECK && xfer) sum <= sum_plus;
    end
  end

endmodule
